fifo_rd_sched: RTL and testbench
================================

Name: fifo_rd_sched

Overview:
- Read-side controller for the async FIFO, in the rclk domain.
- Shares the single FIFO read port among NREQ consumers using round-robin arbitration.
- Owns the read pointer (binary and Gray), the memory read address and the registered empty flag.
- Consumes the already-synchronized write pointer rq2_wptr and feeds rptr back to the write-domain synchronizer.

Parameters:
- ADDRSIZE, 4, FIFO address width; depth = 2^ADDRSIZE; pointers are ADDRSIZE+1 bits.
- NREQ, 4, number of read requesters (2..8).
- MAXBURST, 4, maximum consecutive grants to one requester; used only with RD_BURST_EN (1..15).

Ports:
- rclk  input  1  read-domain clock; all state updates on posedge.
- rrst_n  input  1  reset, synchronous, active-low, sampled on posedge rclk.
- rq2_wptr  input  ADDRSIZE+1  Gray write pointer, already synchronized into rclk.
- req  input  NREQ  per-requester read request, level.
- gnt  output  NREQ  one-hot grant; a word is popped for that requester this cycle.
- rinc  output  1  read strobe = |gnt.
- raddr  output  ADDRSIZE  memory read address = rbin[ADDRSIZE-1:0].
- rptr  output  ADDRSIZE+1  registered Gray read pointer, to the w-domain synchronizer.
- rempty  output  1  registered empty flag.

Behaviour:
- Reset (rrst_n=0 at posedge): rbin=0, rptr=0, rempty=1, last-grant index=NREQ-1 (requester 0 has top priority), burst count=0.
- gnt is combinational:
  - All zero when rempty=1 or req=0.
  - Otherwise one-hot for the first asserted req at or after index (last+1) mod NREQ.
- rinc=|gnt. Memory data at raddr is valid to the granted requester in the same cycle (zero-latency pop).
- On posedge with rinc=1:
  - rbin <= rbin+1, wrapping modulo 2^(ADDRSIZE+1).
  - rptr <= rbinnext ^ (rbinnext>>1).
  - last <= index of granted requester.
- rempty <= (rgraynext == rq2_wptr), where rgraynext is the Gray code of rbin+rinc.
  - The pop of the final word sets rempty on the following edge.
  - No grant is issued in the cycle after the final pop.
- Writes arriving via rq2_wptr clear rempty one rclk after rq2_wptr changes. Total latency from a w-domain write to first grant: 3 rclk minimum.
- Requester stalls (req low) never block others; at most one grant per cycle.
- Simultaneous requests: strict round-robin. With all NREQ requesting continuously and data available, grant order is 0,1,..,NREQ-1,0,...
- Wrap-around: the rbin MSB toggles on each full pass. raddr wraps from 2^ADDRSIZE-1 to 0 with no bubble.
- Reset asserted mid-operation: gnt is still combinational, so a grant may appear during the reset cycle. Its pop is discarded because reset wins. All state returns to reset values at that edge.
- Reset overrides all other updates.

Optional Feature:
- Macro RD_BURST_EN.
- When defined:
  - A granted requester keeps the grant on following cycles while its req stays high and rempty=0, up to MAXBURST consecutive pops.
  - After MAXBURST pops, or on req drop, priority moves to (last+1) mod NREQ.
  - The burst counter resets to 0 on a requester change and on reset.
- When undefined:
  - Priority rotates after every grant, giving a maximum of 1 consecutive pop per requester when others request.
  - A sole requester is still granted every cycle.
  - No burst counter is synthesized.

Test Plan:
- Reset: rrst_n=0 for 2 clocks with req=4'b1111 and rq2_wptr=0. After release: rempty=1, gnt=0, rptr=0, raddr=0 held.
- Single requester, ADDRSIZE=4: rq2_wptr stepped to Gray(3)=5'b00010 with req=4'b0001. Then gnt[0] for exactly 3 cycles, raddr 0,1,2, rptr ends 5'b00010, rempty=1 the next cycle, no 4th grant.
- Round-robin fairness (RD_BURST_EN off): rq2_wptr=Gray(8), req=4'b1111 constant. Grants in order 0,1,2,3,0,1,2,3, then rempty=1.
- Sparse requests: req=4'b1010 with 6 words available. Grants alternate 1,3,1,3,1,3. Raising req[0] mid-sequence after a grant to 3 makes the next grant go to 0.
- Wrap: drive 40 writes/pops with ADDRSIZE=4. raddr wraps 15->0 twice, rptr sequence matches Gray(rbin mod 32), rempty is never falsely low.
- Burst (RD_BURST_EN, MAXBURST=4): req=4'b0011 with 10 words. Grants 0,0,0,0,1,1,1,1,0,0. Deasserting req[0] after 2 pops moves the grant to 1 the next cycle.

Source files
------------

// File: rtl/fifo_rd_sched.sv
// fifo_rd_sched
//   Read-side controller of the async FIFO, clocked by rclk. Arbitrates the
//   single FIFO read port among NREQ consumers (round-robin), owns the read
//   pointer (binary + Gray), the memory read address and the registered empty
//   flag. The pop is zero-latency: the word at raddr belongs to the requester
//   whose gnt bit is high in the same cycle.
//
//   Optional feature: define RD_BURST_EN to let a granted requester keep the
//   grant for up to MAXBURST consecutive pops while its req stays high.
//
// Ports
//   rclk      in   read-domain clock
//   rrst_n    in   synchronous active-low reset
//   rq2_wptr  in   Gray write pointer, already synchronized into rclk
//   req       in   per-requester read request (level)
//   gnt       out  one-hot grant, combinational; a word is popped this cycle
//   rinc      out  read strobe (|gnt)
//   raddr     out  memory read address
//   rptr      out  registered Gray read pointer, to the write-domain sync
//   rempty    out  registered empty flag
module fifo_rd_sched #(
  parameter int ADDRSIZE = 4,
  parameter int NREQ     = 4,
  parameter int MAXBURST = 4
) (
  input  logic                rclk,
  input  logic                rrst_n,
  input  logic [ADDRSIZE:0]   rq2_wptr,
  input  logic [NREQ-1:0]     req,
  output logic [NREQ-1:0]     gnt,
  output logic                rinc,
  output logic [ADDRSIZE-1:0] raddr,
  output logic [ADDRSIZE:0]   rptr,
  output logic                rempty
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  if (NREQ < 2 || NREQ > 8) begin : g_chk_nreq
    $error("fifo_rd_sched: NREQ must be 2..8");
  end
  if (MAXBURST < 1 || MAXBURST > 15) begin : g_chk_burst
    $error("fifo_rd_sched: MAXBURST must be 1..15");
  end

  logic [ADDRSIZE:0] rbin_q, rbin_d;
  logic [ADDRSIZE:0] rptr_q, rptr_d;
  logic              rempty_q, rempty_d;
  logic [IW-1:0]     last_q, last_d;

  logic [IW-1:0]     win_idx;
  logic              win_vld;
  logic [IW-1:0]     rot_idx;
  logic              hold;

`ifdef RD_BURST_EN
  localparam int CW = $clog2(MAXBURST + 1);

  // cnt_q counts consecutive pops of the current burst owner (last_q).
  // Zero means no burst is open (after reset), so the reset value of last_q
  // never grants a burst to requester NREQ-1. A pop won through rotation
  // opens a new burst with a count of one.
  logic [CW-1:0] cnt_q, cnt_d;

  assign hold = (cnt_q != '0) && (cnt_q < CW'(MAXBURST)) && req[last_q];
`else
  assign hold = 1'b0;
`endif

  // Round-robin search starting at last+1. Scanning from the far end down
  // lets the closest asserted request overwrite the others.
  always_comb begin
    win_idx = '0;
    win_vld = 1'b0;
    rot_idx = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      rot_idx = IW'((int'(last_q) + 1 + k) % NREQ);
      if (req[rot_idx]) begin
        win_idx = rot_idx;
        win_vld = 1'b1;
      end
    end
    if (hold) begin
      win_idx = last_q;
      win_vld = 1'b1;
    end
  end

  assign gnt  = (win_vld && !rempty_q) ? (NREQ'(1) << win_idx) : '0;
  assign rinc = |gnt;

  always_comb begin
    rbin_d   = rbin_q + {{ADDRSIZE{1'b0}}, rinc};
    rptr_d   = rbin_d ^ (rbin_d >> 1);
    // Compare the next Gray pointer so the final pop raises rempty on the
    // very edge that consumes the word; no grant can follow it.
    rempty_d = (rptr_d == rq2_wptr);
    last_d   = rinc ? win_idx : last_q;
  end

`ifdef RD_BURST_EN
  always_comb begin
    cnt_d = cnt_q;
    if (rinc) begin
      cnt_d = hold ? (cnt_q + CW'(1)) : CW'(1);
    end
  end
`endif

  always_ff @(posedge rclk) begin
    if (!rrst_n) begin
      rbin_q   <= '0;
      rptr_q   <= '0;
      rempty_q <= 1'b1;
      last_q   <= IW'(NREQ - 1);
`ifdef RD_BURST_EN
      cnt_q    <= '0;
`endif
    end else begin
      rbin_q   <= rbin_d;
      rptr_q   <= rptr_d;
      rempty_q <= rempty_d;
      last_q   <= last_d;
`ifdef RD_BURST_EN
      cnt_q    <= cnt_d;
`endif
    end
  end

  assign raddr  = rbin_q[ADDRSIZE-1:0];
  assign rptr   = rptr_q;
  assign rempty = rempty_q;

endmodule

// File: tb/tb_fifo_rd_sched.sv
module tb_fifo_rd_sched;
  localparam int A  = 4;
  localparam int N  = 4;
  localparam int MB = 4;
  localparam int PW = 32;   // pointer modulus 2^(A+1)
  localparam int D  = 16;   // FIFO depth

  logic         rclk = 1'b0;
  logic         rrst_n;
  logic [A:0]   rq2_wptr;
  logic [N-1:0] req;
  logic [N-1:0] gnt;
  logic         rinc;
  logic [A-1:0] raddr;
  logic [A:0]   rptr;
  logic         rempty;

  int n_cmp = 0;
  int n_bad = 0;
  int w_bin = 0;      // total words written (as seen in rclk domain)
  bit on = 1'b0;

  // reference model state
  int m_rd = 0;       // read count modulo PW
  int m_last = N - 1;
  int m_cnt = 0;
  bit m_empty = 1'b1;

  int gq[$];          // granted requester index per pop
  int aq[$];          // raddr per pop

  fifo_rd_sched #(.ADDRSIZE(A), .NREQ(N), .MAXBURST(MB)) dut (
    .rclk(rclk), .rrst_n(rrst_n), .rq2_wptr(rq2_wptr), .req(req),
    .gnt(gnt), .rinc(rinc), .raddr(raddr), .rptr(rptr), .rempty(rempty)
  );

  always #5 rclk = ~rclk;

  function automatic logic [A:0] gray(int b);
    logic [A:0] v;
    v = b[A:0];
    return v ^ (v >> 1);
  endfunction

  assign rq2_wptr = gray(w_bin);

  // Expected grant: nothing when empty; burst continuation if enabled;
  // otherwise first requester at or after last+1.
  function automatic logic [N-1:0] model_gnt(logic [N-1:0] r);
    logic [N-1:0] g;
    g = '0;
    if (m_empty || r == '0) return g;
`ifdef RD_BURST_EN
    if (m_cnt > 0 && m_cnt < MB && r[m_last]) begin
      g[m_last] = 1'b1;
      return g;
    end
`endif
    for (int k = 0; k < N; k++) begin
      if (r[(m_last + 1 + k) % N]) begin
        g[(m_last + 1 + k) % N] = 1'b1;
        return g;
      end
    end
    return g;
  endfunction

  function automatic int onehot_idx(logic [N-1:0] g);
    for (int i = 0; i < N; i++) if (g[i]) return i;
    return -1;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_seq(string nm, int exp[$]);
    chk({nm, "_len"}, 32'(gq.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size() && i < gq.size(); i++)
      chk(nm, 32'(gq[i]), 32'(exp[i]));
  endtask

  // model update on the active edge (inputs change only #1 after it)
  always @(posedge rclk) begin
    logic [N-1:0] g;
    int j;
    if (!rrst_n) begin
      m_rd = 0; m_last = N - 1; m_cnt = 0; m_empty = 1'b1;
    end else begin
      g = model_gnt(req);
      if (g != '0) begin
        j = onehot_idx(g);
        if (j == m_last && m_cnt > 0 && m_cnt < MB) m_cnt++;
        else m_cnt = 1;
        m_last = j;
        m_rd = (m_rd + 1) % PW;
      end
      m_empty = (m_rd == (w_bin % PW));
    end
  end

  // per-cycle comparison and pop logging
  always @(negedge rclk) begin
    logic [N-1:0] eg;
    if (on) begin
      eg = model_gnt(req);
      chk("gnt",    32'(gnt),    32'(eg));
      chk("rinc",   32'(rinc),   32'(|eg));
      chk("raddr",  32'(raddr),  32'(m_rd % D));
      chk("rptr",   32'(rptr),   32'(gray(m_rd)));
      chk("rempty", 32'(rempty), 32'(m_empty));
      if (gnt != '0) begin
        gq.push_back(onehot_idx(gnt));
        aq.push_back(int'(raddr));
      end
    end
  end

  task automatic tick();
    @(posedge rclk);
    #1;
  endtask

  task automatic do_reset();
    rrst_n = 1'b0;
    req = '0;
    w_bin = 0;
    tick();
    tick();
    rrst_n = 1'b1;
    gq.delete();
    aq.delete();
  endtask

  initial begin
    int e[$];
    int wraps;
    int writes;
    int occ;

    // reset with all requesting
    rrst_n = 1'b0;
    req = '1;
    w_bin = 0;
    tick();
    on = 1'b1;
    tick();
    rrst_n = 1'b1;
    tick();
    tick();
    @(negedge rclk);
    chk("rst_rempty", 32'(rempty), 32'd1);
    chk("rst_gnt",    32'(gnt),    32'd0);
    chk("rst_rptr",   32'(rptr),   32'd0);
    chk("rst_raddr",  32'(raddr),  32'd0);

    // single requester, three words
    do_reset();
    req = 4'b0001;
    w_bin = 3;
    repeat (8) tick();
    @(negedge rclk);
    chk("single_rptr",   32'(rptr),   32'b00010);
    chk("single_rempty", 32'(rempty), 32'd1);
    e = {0, 0, 0};
    chk_seq("single_gnt", e);
    chk("single_a0", 32'(aq.size() > 0 ? aq[0] : -1), 32'd0);
    chk("single_a2", 32'(aq.size() > 2 ? aq[2] : -1), 32'd2);

`ifndef RD_BURST_EN
    // round-robin fairness
    do_reset();
    req = '1;
    w_bin = 8;
    repeat (12) tick();
    @(negedge rclk);
    e = {0, 1, 2, 3, 0, 1, 2, 3};
    chk_seq("rr_gnt", e);
    chk("rr_rempty", 32'(rempty), 32'd1);

    // sparse requests
    do_reset();
    req = 4'b1010;
    w_bin = 6;
    repeat (10) tick();
    e = {1, 3, 1, 3, 1, 3};
    chk_seq("sparse_gnt", e);

    // req[0] raised right after a grant to 3
    do_reset();
    req = 4'b1010;
    w_bin = 4;
    repeat (3) tick();
    req = 4'b1011;
    repeat (6) tick();
    e = {1, 3, 0, 1};
    chk_seq("late_req0", e);
`else
    // burst of MAXBURST each
    do_reset();
    req = 4'b0011;
    w_bin = 10;
    repeat (14) tick();
    e = {0, 0, 0, 0, 1, 1, 1, 1, 0, 0};
    chk_seq("burst_gnt", e);

    // req[0] dropped after two pops
    do_reset();
    req = 4'b0011;
    w_bin = 10;
    repeat (3) tick();
    req = 4'b0010;
    repeat (12) tick();
    e = {0, 0, 1, 1, 1, 1, 1, 1, 1, 1};
    chk_seq("burst_drop", e);

    // sparse requests with bursts
    do_reset();
    req = 4'b1010;
    w_bin = 6;
    repeat (10) tick();
    e = {1, 1, 1, 1, 3, 3};
    chk_seq("sparse_burst", e);
`endif

    // random wrap run: 40 writes, random requests, occupancy kept <= depth
    do_reset();
    writes = 0;
    for (int cyc = 0; cyc < 1000 && gq.size() < 40; cyc++) begin
      req = N'($urandom_range(0, 15));
      occ = ((w_bin % PW) - m_rd + PW) % PW;
      if (writes < 40 && occ < D && $urandom_range(0, 2) != 0) begin
        w_bin++;
        writes++;
      end
      tick();
    end
    chk("wrap_pops", 32'(gq.size()), 32'd40);
    wraps = 0;
    for (int i = 1; i < aq.size(); i++)
      if (aq[i-1] == 15 && aq[i] == 0) wraps++;
    chk("wrap_count", 32'(wraps), 32'd2);

    // reset asserted while popping
    req = '1;
    w_bin = w_bin + 5;
    tick();
    tick();
    rrst_n = 1'b0;
    w_bin = 0;
    tick();
    rrst_n = 1'b1;
    repeat (4) tick();
    @(negedge rclk);
    chk("midrst_rempty", 32'(rempty), 32'd1);
    chk("midrst_rptr",   32'(rptr),   32'd0);

    repeat (2) tick();
    on = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
